// File: rtl/axi_multiport_bridge_if.sv
// rtl/axi_multiport_bridge_if.sv - AXI3 channel bundle between the multiport bridge and the interconnect
interface axi_multiport_bridge_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata_i;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [1:0]      awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;

  logic [ID_W-1:0] wid;
  logic [31:0]     wdata_o;
  logic [3:0]      wstrb_o;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata_i, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata_o, wstrb_o, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata_i, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata_o, wstrb_o, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_multiport_bridge.sv
// rtl/axi_multiport_bridge.sv - NPORT SRAM-like ports onto one AXI3 master: RR reads by id, single in-flight write
module axi_multiport_bridge #(
  parameter int NPORT    = 2,
  parameter int RD_DEPTH = 2,
  parameter int ID_W     = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [NPORT-1:0]      req,
  input  logic [NPORT-1:0]      wr,
  input  logic [2*NPORT-1:0]    size,
  input  logic [32*NPORT-1:0]   addr,
  input  logic [4*NPORT-1:0]    wstrb,
  input  logic [32*NPORT-1:0]   wdata,
  output logic [NPORT-1:0]      addr_ok,
  output logic [NPORT-1:0]      data_ok,
  output logic [31:0]           rdata,
  axi_multiport_bridge_if.master axi
);
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int CW = $clog2(RD_DEPTH + 1);

  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;

  wstate_t          wstate, wstate_nxt;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    rd_cnt [NPORT];
  logic [31:0]      awaddr_q;
  logic [NPORT-1:0] raw_hit, rd_elig, wr_elig, rd_dec, r_hit, b_hit;
  logic [PW:0]      rd_pick, wr_pick;
  logic [PW-1:0]    rd_idx, wr_idx;
  logic             rd_gnt, wr_gnt, rd_idle;
  logic             unused_resp;

  // Returns {found, index} of the first eligible port at or after ptr.
  function automatic logic [PW:0] rr_pick(input logic [NPORT-1:0] elig, input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int j;
    res = '0;
    for (int i = NPORT - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NPORT;
      if (elig[PW'(j)]) res = {1'b1, PW'(j)};
    end
    return res;
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (int'(p) == NPORT - 1) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    raw_hit = '0;
    rd_elig = '0;
    wr_elig = '0;
    rd_dec  = '0;
    r_hit   = '0;
    b_hit   = '0;
    rd_idle = 1'b1;
    for (int p = 0; p < NPORT; p++) begin
      raw_hit[p] = (wstate != W_IDLE) && (addr[32*p+2 +: 30] == awaddr_q[31:2]);
      rd_elig[p] = req[p] & ~wr[p] & (rd_cnt[p] < CW'(RD_DEPTH)) & ~axi.arvalid & ~raw_hit[p];
      wr_elig[p] = req[p] & wr[p];
      rd_dec[p]  = axi.rvalid & axi.rlast & (axi.rid == ID_W'(p));
      r_hit[p]   = axi.rvalid & (axi.rid == ID_W'(p));
      b_hit[p]   = (wstate == W_RESP) & axi.bvalid & (axi.bid == ID_W'(p));
      if (rd_cnt[p] != '0) rd_idle = 1'b0;
    end
  end

  assign rd_pick = rr_pick(rd_elig, rd_ptr);
  assign wr_pick = rr_pick(wr_elig, wr_ptr);
  assign rd_gnt  = rd_pick[PW];
  assign rd_idx  = rd_pick[PW-1:0];
  assign wr_idx  = wr_pick[PW-1:0];

  assign addr_ok = ({NPORT{rd_gnt}} & (NPORT'(1) << rd_idx))
                 | ({NPORT{wr_gnt}} & (NPORT'(1) << wr_idx));

  // Writes wait for all reads to drain so a later write never overtakes an earlier read.
  always_comb begin
    wstate_nxt = wstate;
    wr_gnt     = 1'b0;
    case (wstate)
      W_IDLE: if (wr_pick[PW] && rd_idle) begin
        wr_gnt     = 1'b1;
        wstate_nxt = W_SEND;
      end
      W_SEND: if ((!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready))
        wstate_nxt = W_RESP;
      W_RESP: if (axi.bvalid) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) wstate <= W_IDLE;
    else        wstate <= wstate_nxt;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.arid    <= '0;
      axi.arsize  <= '0;
      rd_ptr      <= '0;
      data_ok     <= '0;
      rdata       <= '0;
      for (int p = 0; p < NPORT; p++) rd_cnt[p] <= '0;
    end else begin
      if (rd_gnt) begin
        axi.arvalid <= 1'b1;
        axi.araddr  <= addr[32*rd_idx +: 32];
        axi.arid    <= ID_W'(rd_idx);
        axi.arsize  <= {1'b0, size[2*rd_idx +: 2]};
        rd_ptr      <= ptr_next(rd_idx);
      end else if (axi.arready) begin
        axi.arvalid <= 1'b0;
      end
      for (int p = 0; p < NPORT; p++) begin
        if ((rd_gnt && rd_idx == PW'(p)) && !rd_dec[p])
          rd_cnt[p] <= rd_cnt[p] + CW'(1);
        else if (!(rd_gnt && rd_idx == PW'(p)) && rd_dec[p])
          rd_cnt[p] <= rd_cnt[p] - CW'(1);
      end
      data_ok <= r_hit | b_hit;
      if (|r_hit) rdata <= axi.rdata_i;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      axi.awvalid <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.awid    <= '0;
      axi.awsize  <= '0;
      axi.wid     <= '0;
      axi.wdata_o <= '0;
      axi.wstrb_o <= '0;
      awaddr_q    <= '0;
      wr_ptr      <= '0;
    end else if (wr_gnt) begin
      axi.awvalid <= 1'b1;
      axi.wvalid  <= 1'b1;
      axi.awid    <= ID_W'(wr_idx);
      axi.awsize  <= {1'b0, size[2*wr_idx +: 2]};
      axi.wid     <= ID_W'(wr_idx);
      axi.wdata_o <= wdata[32*wr_idx +: 32];
      axi.wstrb_o <= wstrb[4*wr_idx +: 4];
      awaddr_q    <= addr[32*wr_idx +: 32];
      wr_ptr      <= ptr_next(wr_idx);
    end else if (wstate == W_SEND) begin
      if (axi.awready) axi.awvalid <= 1'b0;
      if (axi.wready)  axi.wvalid  <= 1'b0;
    end
  end

  assign axi.awaddr  = awaddr_q;
  assign axi.bready  = (wstate == W_RESP);
  assign axi.rready  = 1'b1;
  assign axi.wlast   = 1'b1;
  assign axi.arlen   = 8'd0;
  assign axi.arburst = 2'd1;
  assign axi.arlock  = 2'd0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.awlen   = 8'd0;
  assign axi.awburst = 2'd1;
  assign axi.awlock  = 2'd0;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;

  assign unused_resp = ^{axi.rresp, axi.bresp};
endmodule

// File: tb/tb_axi_multiport_bridge.sv
// tb/tb_axi_multiport_bridge.sv - directed checks of the multiport AXI bridge
module tb_axi_multiport_bridge;
  localparam int NPORT = 2, RD_DEPTH = 2, ID_W = 4;

  logic        aclk, areset;
  logic [1:0]  req, wr;
  logic [3:0]  size;
  logic [63:0] addr, wdata;
  logic [7:0]  wstrb;
  logic [1:0]  addr_ok, data_ok;
  logic [31:0] rdata;

  axi_multiport_bridge_if #(.ID_W(ID_W)) axi ();

  axi_multiport_bridge #(.NPORT(NPORT), .RD_DEPTH(RD_DEPTH), .ID_W(ID_W)) dut (
    .aclk(aclk), .areset(areset), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .axi(axi)
  );

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; wr = '0; size = '0; addr = '0; wdata = '0; wstrb = '0;
    axi.arready = 0; axi.rid = '0; axi.rdata_i = '0; axi.rresp = '0; axi.rlast = 0; axi.rvalid = 0;
    axi.awready = 0; axi.wready = 0; axi.bid = '0; axi.bresp = '0; axi.bvalid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
  endtask

  task automatic rd_port(input int p, input logic [31:0] a, input logic [1:0] sz);
    req[p] = 1'b1;
    wr[p]  = 1'b0;
    addr[32*p +: 32] = a;
    size[2*p +: 2]   = sz;
  endtask

  task automatic wr_port(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req[p] = 1'b1;
    wr[p]  = 1'b1;
    addr[32*p +: 32]  = a;
    wdata[32*p +: 32] = d;
    wstrb[4*p +: 4]   = s;
    size[2*p +: 2]    = 2'd2;
  endtask

  task automatic r_beat(input int id, input logic [31:0] d);
    axi.rvalid  = 1'b1;
    axi.rlast   = 1'b1;
    axi.rid     = ID_W'(id);
    axi.rdata_i = d;
  endtask

  logic [1:0] t2_exp [10];

  initial begin
    t2_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};

    // reset state
    clear_inputs();
    areset = 1'b1;
    step();
    settle();
    check("rst_arvalid", axi.arvalid, 0);
    check("rst_awvalid", axi.awvalid, 0);
    check("rst_wvalid",  axi.wvalid, 0);
    check("rst_bready",  axi.bready, 0);
    check("rst_data_ok", data_ok, 0);
    check("rst_rdata",   rdata, 0);
    areset = 1'b0;
    step();

    // single word read on port 0
    axi.arready = 1'b1;
    rd_port(0, 32'h1c00_0000, 2'd2);
    settle();
    check("t1_addr_ok", addr_ok, 2'b01);
    step();
    req = '0;
    settle();
    check("t1_arvalid", axi.arvalid, 1);
    check("t1_araddr",  axi.araddr, 32'h1c00_0000);
    check("t1_arid",    axi.arid, 0);
    check("t1_arsize",  axi.arsize, 3'd2);
    check("t1_arlen",   axi.arlen, 0);
    check("t1_arburst", axi.arburst, 2'd1);
    check("t1_rready",  axi.rready, 1);
    step();
    check("t1_ar_drop", axi.arvalid, 0);
    r_beat(0, 32'hDEAD_BEEF);
    step();
    axi.rvalid = 1'b0;
    check("t1_data_ok", data_ok, 2'b01);
    check("t1_rdata",   rdata, 32'hDEAD_BEEF);
    step();
    check("t1_data_ok_clr", data_ok, 2'b00);

    // round-robin with per-port depth stall
    do_reset();
    axi.arready = 1'b1;
    rd_port(0, 32'h1000, 2'd2);
    rd_port(1, 32'h2000, 2'd2);
    for (int k = 0; k < 10; k++) begin
      settle();
      check($sformatf("t2_addr_ok_%0d", k), addr_ok, t2_exp[k]);
      step();
    end
    check("t2_arid_last", axi.arid, 1);
    req = '0;
    for (int k = 0; k < 4; k++) begin
      r_beat(k % 2, 32'h0000_00A0 + k);
      step();
      check($sformatf("t2_data_ok_%0d", k), data_ok, (k % 2) ? 2'b10 : 2'b01);
      check($sformatf("t2_rdata_%0d", k), rdata, 32'h0000_00A0 + k);
    end
    axi.rvalid = 1'b0;
    rd_port(0, 32'h1000, 2'd2);
    rd_port(1, 32'h2000, 2'd2);
    settle();
    check("t2_resume", addr_ok, 2'b01);

    // write on port 1 with late wready
    do_reset();
    axi.awready = 1'b1;
    wr_port(1, 32'h100, 32'h1234_5678, 4'hF);
    settle();
    check("t3_addr_ok", addr_ok, 2'b10);
    step();
    settle();
    check("t3_awvalid", axi.awvalid, 1);
    check("t3_wvalid",  axi.wvalid, 1);
    check("t3_awaddr",  axi.awaddr, 32'h100);
    check("t3_awid",    axi.awid, 1);
    check("t3_wid",     axi.wid, 1);
    check("t3_wdata",   axi.wdata_o, 32'h1234_5678);
    check("t3_wstrb",   axi.wstrb_o, 4'hF);
    check("t3_wlast",   axi.wlast, 1);
    check("t3_busy_ok", addr_ok, 2'b00);
    step();
    check("t3_aw_drop", axi.awvalid, 0);
    check("t3_w_hold1", axi.wvalid, 1);
    step();
    check("t3_w_hold2", axi.wvalid, 1);
    step();
    check("t3_w_hold3", axi.wvalid, 1);
    axi.wready = 1'b1;
    step();
    axi.wready = 1'b0;
    settle();
    check("t3_w_drop", axi.wvalid, 0);
    check("t3_bready", axi.bready, 1);
    check("t3_resp_ok", addr_ok, 2'b00);
    axi.bvalid = 1'b1;
    axi.bid    = ID_W'(1);
    req = '0;
    step();
    axi.bvalid = 1'b0;
    check("t3_data_ok", data_ok, 2'b10);
    check("t3_bready_clr", axi.bready, 0);

    // RAW protection
    do_reset();
    axi.arready = 1'b1;
    wr_port(1, 32'h100, 32'hCAFE_0001, 4'hF);
    settle();
    check("t4_wr_ok", addr_ok, 2'b10);
    step();
    req = '0;
    wr  = '0;
    rd_port(0, 32'h200, 2'd2);
    settle();
    check("t4_far_read", addr_ok, 2'b01);
    step();
    rd_port(0, 32'h102, 2'd1);
    step();
    settle();
    check("t4_raw_send", addr_ok, 2'b00);
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    step();
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    settle();
    check("t4_raw_resp", addr_ok, 2'b00);
    check("t4_bready",   axi.bready, 1);
    axi.bvalid = 1'b1;
    axi.bid    = ID_W'(1);
    step();
    axi.bvalid = 1'b0;
    settle();
    check("t4_data_ok", data_ok, 2'b10);
    check("t4_raw_free", addr_ok, 2'b01);

    // out-of-order and out-of-range rid
    do_reset();
    axi.arready = 1'b1;
    rd_port(0, 32'h300, 2'd2);
    rd_port(1, 32'h400, 2'd2);
    settle();
    check("t5_gnt0", addr_ok, 2'b01);
    step();
    step();
    settle();
    check("t5_gnt1", addr_ok, 2'b10);
    step();
    req = '0;
    step();
    r_beat(1, 32'h1111_2222);
    step();
    check("t5_ok_p1",  data_ok, 2'b10);
    check("t5_data_p1", rdata, 32'h1111_2222);
    r_beat(0, 32'h3333_4444);
    step();
    check("t5_ok_p0",  data_ok, 2'b01);
    check("t5_data_p0", rdata, 32'h3333_4444);
    r_beat(5, 32'h5555_6666);
    step();
    axi.rvalid = 1'b0;
    check("t5_ok_rid5",   data_ok, 2'b00);
    check("t5_data_rid5", rdata, 32'h3333_4444);

    // asynchronous reset with AR and W pending
    do_reset();
    rd_port(0, 32'h500, 2'd2);
    wr_port(1, 32'h600, 32'hBEEF_0000, 4'h3);
    settle();
    check("t6_dual_gnt", addr_ok, 2'b11);
    step();
    req = '0;
    wr  = '0;
    settle();
    check("t6_pre_ar", axi.arvalid, 1);
    check("t6_pre_aw", axi.awvalid, 1);
    check("t6_pre_w",  axi.wvalid, 1);
    #2;
    areset = 1'b1;
    #1;
    check("t6_rst_ar", axi.arvalid, 0);
    check("t6_rst_aw", axi.awvalid, 0);
    check("t6_rst_w",  axi.wvalid, 0);
    check("t6_rst_b",  axi.bready, 0);
    step();
    step();
    areset = 1'b0;
    rd_port(0, 32'h700, 2'd2);
    wr_port(1, 32'h800, 32'h0, 4'h1);
    settle();
    check("t6_post_gnt", addr_ok, 2'b11);
    step();
    check("t6_post_ar",   axi.arvalid, 1);
    check("t6_post_addr", axi.araddr, 32'h700);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
